// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program-counter sequencer for the 16-bit core.
// Owns the architectural PC and drives instruction-memory fetch requests. It
// merges decode-stage branch redirects, hazard stalls and HLT detection, and
// tolerates a variable-latency imem through a ready handshake with a timeout.
//
// Optional feature macro: TAKEN_CNT_EN adds the taken_cnt register and port.
//
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset
//   stall            hazard unit holds IF
//   br_taken         branch resolved taken in decode; br_target is the redirect
//   is_halt          instruction returned by imem this cycle is HLT
//   imem_ready       imem data for imem_addr is valid this cycle
//   imem_req         fetch request (low only when halted)
//   imem_addr        fetch address (= pc)
//   pc, pc_plus2     current fetch PC and pc + 2 (mod 2^16)
//   if_valid         write IF/ID with the current instruction this cycle
//   flush            squash IF/ID contents
//   halted           core halted (terminal until reset)
//   fetch_err        sticky imem timeout flag
//   taken_cnt        taken-redirect count (TAKEN_CNT_EN only)
module pc_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  input  logic        is_halt,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        if_valid,
  output logic        flush,
  output logic        halted,
  output logic        fetch_err
`ifdef TAKEN_CNT_EN
  ,
  output logic [15:0] taken_cnt
`endif
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pc_nxt;
  logic [7:0]  wait_cnt, wait_nxt;
  logic        err_nxt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      wait_cnt  <= 8'd0;
      fetch_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      wait_cnt  <= wait_nxt;
      fetch_err <= err_nxt;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    wait_nxt  = wait_cnt;
    err_nxt   = fetch_err;
    imem_req  = 1'b0;
    flush     = 1'b0;
    if_valid  = 1'b0;

    if (state != HALT) begin
      imem_req = 1'b1;
      flush    = br_taken;
      if_valid = imem_ready & ~stall & ~br_taken;

      if (br_taken) begin
        // Redirect abandons whatever fetch was in flight.
        pc_nxt    = br_target;
        state_nxt = FETCH;
        wait_nxt  = 8'd0;
      end else if (imem_ready && !stall && is_halt) begin
        // pc keeps pointing at the HLT instruction.
        state_nxt = HALT;
      end else if (imem_ready && !stall) begin
        pc_nxt    = pc + 16'd2;
        state_nxt = FETCH;
        wait_nxt  = 8'd0;
      end else if (imem_ready) begin
        // Stalled but memory answered: drop the data and refetch the same pc.
        // The wait counter tracks consecutive unanswered cycles, so it restarts.
        state_nxt = FETCH;
        wait_nxt  = 8'd0;
      end else if (state == WAIT && wait_cnt == TIMEOUT_CNT) begin
        err_nxt   = 1'b1;
        state_nxt = HALT;
      end else begin
        state_nxt = WAIT;
        wait_nxt  = wait_cnt + 8'd1;
      end
    end
  end

  assign halted    = (state == HALT);
  assign imem_addr = pc;
  assign pc_plus2  = pc + 16'd2;

`ifdef TAKEN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt <= 16'd0;
    end else if (state != HALT && br_taken) begin
      taken_cnt <= taken_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios followed by randomized
// traffic checked against a cycle-level behavioural model of the PC rules.
module tb_pc_sequencer;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_target = 16'h0000;
  logic        is_halt = 1'b0;
  logic        imem_ready = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        if_valid;
  logic        flush;
  logic        halted;
  logic        fetch_err;
`ifdef TAKEN_CNT_EN
  logic [15:0] taken_cnt;
`endif

  int checks = 0;
  int passes = 0;

  pc_sequencer #(.RESET_PC(16'h0000), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .is_halt   (is_halt),
    .imem_ready(imem_ready),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .pc        (pc),
    .pc_plus2  (pc_plus2),
    .if_valid  (if_valid),
    .flush     (flush),
    .halted    (halted),
    .fetch_err (fetch_err)
`ifdef TAKEN_CNT_EN
    ,
    .taken_cnt (taken_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  // Apply one cycle of inputs; time stays 1 ns after the last rising edge + 1.
  task automatic drive(input logic s, input logic b, input logic [15:0] t,
                       input logic h, input logic r);
    stall = s; br_taken = b; br_target = t; is_halt = h; imem_ready = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset with idle inputs; releases shortly after a rising edge so the next
  // drive() is the first functional cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    stall = 1'b0; br_taken = 1'b0; br_target = 16'h0000; is_halt = 1'b0; imem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    stall = 1'b0; br_taken = 1'b0; is_halt = 1'b0; imem_ready = 1'b0;
    #2;
    checks++; if (pc !== 16'h0000) $display("FAIL reset_pc: got %h expected 0000", pc); else passes++;
    checks++; if (imem_addr !== 16'h0000) $display("FAIL reset_addr: got %h expected 0000", imem_addr); else passes++;
    checks++; if (imem_req !== 1'b1) $display("FAIL reset_req: got %b expected 1", imem_req); else passes++;
    checks++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b expected 0", halted); else passes++;
    checks++; if (fetch_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", fetch_err); else passes++;
    checks++; if (if_valid !== 1'b0) $display("FAIL reset_ifv: got %b expected 0", if_valid); else passes++;
`ifdef TAKEN_CNT_EN
    checks++; if (taken_cnt !== 16'h0000) $display("FAIL reset_taken: got %h expected 0000", taken_cnt); else passes++;
`endif
    do_reset();
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 16'h0, 0, 1);
      checks++; if (pc !== 16'(2 * i)) $display("FAIL seq_pc%0d: got %h expected %h", i, pc, 16'(2 * i)); else passes++;
      checks++; if (imem_addr !== 16'(2 * i)) $display("FAIL seq_addr%0d: got %h expected %h", i, imem_addr, 16'(2 * i)); else passes++;
      checks++; if (if_valid !== 1'b1) $display("FAIL seq_ifv%0d: got %b expected 1", i, if_valid); else passes++;
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive(0, 1, 16'h0010, 0, 0); tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 16'h0, 0, 1);
      checks++; if (pc !== 16'h0010) $display("FAIL stall_pc%0d: got %h expected 0010", i, pc); else passes++;
      checks++; if (if_valid !== 1'b0) $display("FAIL stall_ifv%0d: got %b expected 0", i, if_valid); else passes++;
      tick();
    end
    drive(0, 0, 16'h0, 0, 1);
    checks++; if (if_valid !== 1'b1) $display("FAIL stall_release_ifv: got %b expected 1", if_valid); else passes++;
    tick();
    drive(0, 0, 16'h0, 0, 1);
    checks++; if (pc !== 16'h0012) $display("FAIL stall_release_pc: got %h expected 0012", pc); else passes++;
    tick();
  endtask

  task automatic test_branch_wait();
    do_reset();
    drive(0, 0, 16'h0, 0, 0); tick();
    drive(0, 0, 16'h0, 0, 0); tick();
    drive(0, 1, 16'h0040, 0, 0);
    checks++; if (flush !== 1'b1) $display("FAIL brw_flush: got %b expected 1", flush); else passes++;
    checks++; if (if_valid !== 1'b0) $display("FAIL brw_ifv: got %b expected 0", if_valid); else passes++;
    tick();
    drive(0, 0, 16'h0, 0, 0);
    checks++; if (pc !== 16'h0040) $display("FAIL brw_pc: got %h expected 0040", pc); else passes++;
    checks++; if (flush !== 1'b0) $display("FAIL brw_flush_after: got %b expected 0", flush); else passes++;
`ifdef TAKEN_CNT_EN
    checks++; if (taken_cnt !== 16'h0001) $display("FAIL brw_taken: got %h expected 0001", taken_cnt); else passes++;
`endif
    // The redirect cleared the wait count: 15 more misses must not time out.
    tick();
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      drive(0, 0, 16'h0, 0, 0); tick();
    end
    drive(0, 0, 16'h0, 0, 1);
    checks++; if (if_valid !== 1'b1) $display("FAIL brw_recover_ifv: got %b expected 1", if_valid); else passes++;
    checks++; if (fetch_err !== 1'b0) $display("FAIL brw_recover_err: got %b expected 0", fetch_err); else passes++;
    tick();
  endtask

  task automatic test_timeout();
    // Exactly TIMEOUT misses then ready: no error.
    do_reset();
    for (int i = 0; i < TIMEOUT; i++) begin
      drive(0, 0, 16'h0, 0, 0); tick();
    end
    drive(0, 0, 16'h0, 0, 1);
    checks++; if (if_valid !== 1'b1) $display("FAIL to_edge_ifv: got %b expected 1", if_valid); else passes++;
    checks++; if (halted !== 1'b0) $display("FAIL to_edge_halted: got %b expected 0", halted); else passes++;
    tick();
    drive(0, 0, 16'h0, 0, 1);
    checks++; if (pc !== 16'h0002) $display("FAIL to_edge_pc: got %h expected 0002", pc); else passes++;
    tick();
    // TIMEOUT + 1 misses: error.
    do_reset();
    for (int i = 0; i < TIMEOUT + 1; i++) begin
      drive(0, 0, 16'h0, 0, 0);
      checks++; if (halted !== 1'b0) $display("FAIL to_early_halt%0d: got %b expected 0", i, halted); else passes++;
      tick();
    end
    drive(0, 1, 16'h0100, 0, 1);
    checks++; if (fetch_err !== 1'b1) $display("FAIL to_err: got %b expected 1", fetch_err); else passes++;
    checks++; if (halted !== 1'b1) $display("FAIL to_halted: got %b expected 1", halted); else passes++;
    checks++; if (imem_req !== 1'b0) $display("FAIL to_req: got %b expected 0", imem_req); else passes++;
    checks++; if (flush !== 1'b0) $display("FAIL to_flush: got %b expected 0", flush); else passes++;
    checks++; if (if_valid !== 1'b0) $display("FAIL to_ifv: got %b expected 0", if_valid); else passes++;
    tick();
    drive(0, 0, 16'h0, 0, 1);
    checks++; if (pc !== 16'h0000) $display("FAIL to_br_ignored: got %h expected 0000", pc); else passes++;
    checks++; if (halted !== 1'b1) $display("FAIL to_still_halted: got %b expected 1", halted); else passes++;
    tick();
  endtask

  task automatic test_halt();
    do_reset();
    drive(0, 1, 16'h0020, 0, 0); tick();
    drive(0, 0, 16'h0, 1, 1);
    checks++; if (if_valid !== 1'b1) $display("FAIL hlt_ifv: got %b expected 1", if_valid); else passes++;
    tick();
    drive(0, 1, 16'h0050, 0, 1);
    checks++; if (halted !== 1'b1) $display("FAIL hlt_halted: got %b expected 1", halted); else passes++;
    checks++; if (pc !== 16'h0020) $display("FAIL hlt_pc: got %h expected 0020", pc); else passes++;
    checks++; if (imem_req !== 1'b0) $display("FAIL hlt_req: got %b expected 0", imem_req); else passes++;
    checks++; if (fetch_err !== 1'b0) $display("FAIL hlt_err: got %b expected 0", fetch_err); else passes++;
    tick();
    drive(0, 0, 16'h0, 0, 1);
    checks++; if (pc !== 16'h0020) $display("FAIL hlt_pc_hold: got %h expected 0020", pc); else passes++;
    tick();
    // Redirect outranks HLT in the same cycle.
    do_reset();
    drive(0, 1, 16'h0020, 0, 0); tick();
    drive(0, 1, 16'h0030, 1, 1);
    checks++; if (flush !== 1'b1) $display("FAIL hltbr_flush: got %b expected 1", flush); else passes++;
    tick();
    drive(0, 0, 16'h0, 0, 0);
    checks++; if (halted !== 1'b0) $display("FAIL hltbr_halted: got %b expected 0", halted); else passes++;
    checks++; if (pc !== 16'h0030) $display("FAIL hltbr_pc: got %h expected 0030", pc); else passes++;
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    drive(0, 1, 16'hFFFE, 0, 0); tick();
    drive(0, 0, 16'h0, 0, 1);
    checks++; if (pc_plus2 !== 16'h0000) $display("FAIL wrap_plus2: got %h expected 0000", pc_plus2); else passes++;
    tick();
    drive(0, 1, 16'h0041, 0, 1);
    checks++; if (pc !== 16'h0000) $display("FAIL wrap_pc: got %h expected 0000", pc); else passes++;
    tick();
    drive(0, 0, 16'h0, 0, 0);
    checks++; if (pc !== 16'h0041) $display("FAIL odd_target: got %h expected 0041", pc); else passes++;
    tick();
  endtask

  task automatic test_async_reset();
    // From a timed-out state, reset clears the error without a clock edge.
    do_reset();
    for (int i = 0; i < TIMEOUT + 1; i++) begin
      drive(0, 0, 16'h0, 0, 0); tick();
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (fetch_err !== 1'b0) $display("FAIL arst_err: got %b expected 0", fetch_err); else passes++;
    checks++; if (halted !== 1'b0) $display("FAIL arst_halted: got %b expected 0", halted); else passes++;
    do_reset();
    // Mid-WAIT at a nonzero pc.
    drive(0, 1, 16'h0200, 0, 0); tick();
    drive(0, 0, 16'h0, 0, 0); tick();
    drive(0, 0, 16'h0, 0, 0); tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pc !== 16'h0000) $display("FAIL arst_pc: got %h expected 0000", pc); else passes++;
    checks++; if (imem_req !== 1'b1) $display("FAIL arst_req: got %b expected 1", imem_req); else passes++;
    do_reset();
  endtask

  task automatic test_random();
    logic [15:0] m_pc;
    logic [15:0] m_taken;
    bit          m_halted;
    bit          m_err;
    int          m_miss;
    int          mode;
    bit          e_req, e_flush, e_ifv;
    logic        s, b, h, r;
    logic [15:0] t;

    do_reset();
    m_pc = 16'h0000; m_taken = 16'h0000; m_halted = 0; m_err = 0; m_miss = 0; mode = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc % 32 == 0) mode = int'($urandom_range(0, 2));
      if (m_halted && $urandom_range(0, 3) == 0) begin
        do_reset();
        m_pc = 16'h0000; m_taken = 16'h0000; m_halted = 0; m_err = 0; m_miss = 0;
      end
      s = ($urandom_range(0, 3) == 0);
      h = ($urandom_range(0, 15) == 0);
      t = 16'($urandom);
      if (mode == 0) begin
        r = ($urandom_range(0, 9) != 0); b = ($urandom_range(0, 7) == 0);
      end else if (mode == 1) begin
        r = ($urandom_range(0, 1) == 0); b = ($urandom_range(0, 7) == 0);
      end else begin
        r = ($urandom_range(0, 29) == 0); b = ($urandom_range(0, 63) == 0);
      end
      drive(s, b, t, h, r);

      e_req   = !m_halted;
      e_flush = !m_halted && b;
      e_ifv   = !m_halted && r && !s && !b;
      checks++; if (pc !== m_pc) $display("FAIL rnd_pc c%0d: got %h expected %h", cyc, pc, m_pc); else passes++;
      checks++; if (imem_addr !== m_pc) $display("FAIL rnd_addr c%0d: got %h expected %h", cyc, imem_addr, m_pc); else passes++;
      checks++; if (pc_plus2 !== 16'(m_pc + 16'd2)) $display("FAIL rnd_plus2 c%0d: got %h expected %h", cyc, pc_plus2, 16'(m_pc + 16'd2)); else passes++;
      checks++; if (imem_req !== e_req) $display("FAIL rnd_req c%0d: got %b expected %b", cyc, imem_req, e_req); else passes++;
      checks++; if (flush !== e_flush) $display("FAIL rnd_flush c%0d: got %b expected %b", cyc, flush, e_flush); else passes++;
      checks++; if (if_valid !== e_ifv) $display("FAIL rnd_ifv c%0d: got %b expected %b", cyc, if_valid, e_ifv); else passes++;
      checks++; if (halted !== m_halted) $display("FAIL rnd_halted c%0d: got %b expected %b", cyc, halted, m_halted); else passes++;
      checks++; if (fetch_err !== m_err) $display("FAIL rnd_err c%0d: got %b expected %b", cyc, fetch_err, m_err); else passes++;
`ifdef TAKEN_CNT_EN
      checks++; if (taken_cnt !== m_taken) $display("FAIL rnd_taken c%0d: got %h expected %h", cyc, taken_cnt, m_taken); else passes++;
`endif

      // Reference rules: m_miss counts consecutive cycles without a response.
      if (!m_halted) begin
        if (b) begin
          m_pc = t; m_miss = 0; m_taken = m_taken + 16'd1;
        end else if (r && !s && h) begin
          m_halted = 1;
        end else if (r && !s) begin
          m_pc = m_pc + 16'd2; m_miss = 0;
        end else if (r) begin
          m_miss = 0;
        end else if (m_miss == TIMEOUT) begin
          m_err = 1; m_halted = 1;
        end else begin
          m_miss = m_miss + 1;
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_wait();
    test_timeout();
    test_halt();
    test_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
